// File: rtl/regfile_wb_scheduler_pkg.sv
// Purpose: shared writeback request type and source indices for the regfile write-port scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none. Shared with the execute and memory units that build writeback requests.
package regfile_wb_scheduler_pkg;

   localparam int RF_AW = 5;   // register index width
   localparam int RF_DW = 32;  // writeback data width

   // Bit positions of each writeback source in request/grant vectors.
   localparam logic WB_SRC_ALU = 1'b0;
   localparam logic WB_SRC_LSU = 1'b1;

   typedef struct packed {
      logic [RF_AW-1:0] rd;
      logic [RF_DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Purpose: bundles the writeback requests, issue/hazard signals and regfile write port.
// Latency: n/a (wiring only).
// Backpressure: alu_ready/lsu_ready come back from the scheduler; sources hold requests until ready.
// Modports: master = execute/memory/decode side, slave = the scheduler.
interface regfile_wb_scheduler_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic [AW-1:0] issue_rs1;
   logic [AW-1:0] issue_rs2;
   logic          hazard;
   logic          wren;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WData;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output issue_valid, issue_rd, issue_rs1, issue_rs2,
      input  alu_ready, lsu_ready, hazard, wren, WriteReg, WData
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  issue_valid, issue_rd, issue_rs1, issue_rs2,
      output alu_ready, lsu_ready, hazard, wren, WriteReg, WData
   );
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Purpose: 2-way round-robin arbiter with a 1-bit priority pointer and one-hot grant.
// Latency: grant is combinational from req; pointer updates on posedge.
// Backpressure: a requester not granted simply waits; at most one grant per cycle.
// Ports: clk, rst (sync, active-high), req[1:0] in, gnt[1:0] one-hot out.
module regfile_wb_scheduler_rr_arbiter2
   import regfile_wb_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q names the source that wins the next contested cycle.
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt   = req;
      ptr_d = ptr_q;
      if (req == 2'b11) begin
         gnt   = (ptr_q == WB_SRC_LSU) ? 2'b10 : 2'b01;
         // Only contested grants move the pointer; a lone requester wins outright.
         ptr_d = ~ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= WB_SRC_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Purpose: shares the single regfile write port between ALU and LSU and tracks pending writes.
// Latency: grant in cycle N -> wren/WriteReg/WData in cycle N+1; hazard is combinational.
// Backpressure: valid/ready per source, one grant per cycle, round-robin on contention; no ready in rst.
// Ports: clk, rst (sync, active-high), bus (slave modport: ALU/LSU requests, issue/hazard, regfile write).
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int ADDRESS_WIDTH = RF_AW,
   parameter int DATA_WIDTH    = RF_DW
)(
   input  logic                   clk,
   input  logic                   rst,
   regfile_wb_scheduler_if.slave  bus
);

   localparam int NREGS = 2 ** ADDRESS_WIDTH;

   logic [1:0]       req;
   logic [1:0]       gnt;
   logic             any_gnt;
   wb_req_t          sel;

   wb_req_t          wb_q,    wb_d;
   logic             wren_q,  wren_d;
   logic [NREGS-1:0] busy_q,  busy_d;
   logic             hazard;

   // Requests are masked during reset so nothing is accepted and the pointer stays put.
   always_comb begin
      req             = '0;
      req[WB_SRC_ALU] = bus.alu_valid & ~rst;
      req[WB_SRC_LSU] = bus.lsu_valid & ~rst;
   end

   regfile_wb_scheduler_rr_arbiter2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign any_gnt       = |gnt;
   assign bus.alu_ready = gnt[WB_SRC_ALU];
   assign bus.lsu_ready = gnt[WB_SRC_LSU];

   always_comb begin
      sel.rd   = bus.lsu_rd;
      sel.data = bus.lsu_data;
      if (gnt[WB_SRC_ALU]) begin
         sel.rd   = bus.alu_rd;
         sel.data = bus.alu_data;
      end
   end

   // Reads the current scoreboard only; a grant in this cycle does not unblock decode until next cycle.
   assign hazard = busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2]
                 | (bus.issue_valid & busy_q[bus.issue_rd]);

   always_comb begin
      wb_d   = wb_q;
      wren_d = 1'b0;
      busy_d = busy_q;
      if (any_gnt) begin
         wb_d             = sel;
         // x0 writes are accepted and dropped here.
         wren_d           = (sel.rd != '0);
         busy_d[sel.rd]   = 1'b0;
      end
      // Applied after the clear so a newer writer of the same register stays pending.
      if (bus.issue_valid && !hazard && (bus.issue_rd != '0)) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= '0;
         wren_q <= 1'b0;
         busy_q <= '0;
      end else begin
         wb_q   <= wb_d;
         wren_q <= wren_d;
         busy_q <= busy_d;
      end
   end

   assign bus.hazard   = hazard;
   assign bus.wren     = wren_q;
   assign bus.WriteReg = wb_q.rd;
   assign bus.WData    = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   regfile_wb_scheduler_if #(.AW(5), .DW(32)) bus ();

   regfile_wb_scheduler #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge; inputs change here and outputs settle 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
      bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;

      // 1. Reset: no acceptance while rst is high, outputs cleared, then idle.
      step();
      bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1;
      #1;
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_lsu_ready", bus.lsu_ready, 0);
      step();
      chk("rst_wren", bus.wren, 0);
      chk("rst_writereg", bus.WriteReg, 0);
      chk("rst_wdata", bus.WData, 0);
      chk("rst_hazard", bus.hazard, 0);
      rst = 1'b0; bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      step();
      chk("idle_wren", bus.wren, 0);

      // 2. ALU alone: rd=5, data=0x1234.
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
      #1;
      chk("alu_only_ready", bus.alu_ready, 1);
      chk("alu_only_lsu_ready", bus.lsu_ready, 0);
      step();
      bus.alu_valid = 1'b0;
      chk("alu_only_wren", bus.wren, 1);
      chk("alu_only_writereg", bus.WriteReg, 5);
      chk("alu_only_wdata", bus.WData, 32'h1234);
      step();
      chk("alu_only_wren_one_cycle", bus.wren, 0);

      // 3. Both valid each cycle: ALU, LSU, ALU (pointer still ALU after uncontested grant).
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
      #1;
      chk("rr0_ready", {bus.alu_ready, bus.lsu_ready}, 2'b10);
      step();
      chk("rr0_wren", bus.wren, 1);
      chk("rr0_writereg", bus.WriteReg, 6);
      chk("rr1_ready", {bus.alu_ready, bus.lsu_ready}, 2'b01);
      step();
      chk("rr1_writereg", bus.WriteReg, 7);
      chk("rr1_wdata", bus.WData, 32'h77);
      chk("rr2_ready", {bus.alu_ready, bus.lsu_ready}, 2'b10);
      step();
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      chk("rr2_wren", bus.wren, 1);
      chk("rr2_writereg", bus.WriteReg, 6);
      chk("rr2_wdata", bus.WData, 32'h66);
      // Pointer now favours LSU.

      // 4. Writes to x0.
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hdead;
      #1;
      chk("x0_lsu_ready", bus.lsu_ready, 1);
      step();
      bus.lsu_valid = 1'b0;
      chk("x0_wren", bus.wren, 0);
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
      step();
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd0;
      #1;
      chk("x0_hazard", bus.hazard, 0);

      // 5. Scoreboard hazards on x8.
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_rs1 = 5'd1; bus.issue_rs2 = 5'd2;
      #1;
      chk("sb_issue_no_hazard", bus.hazard, 0);
      step();
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd8;
      #1;
      chk("sb_raw_hazard", bus.hazard, 1);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd8; bus.lsu_data = 32'h88;
      #1;
      chk("sb_lsu_ready", bus.lsu_ready, 1);
      chk("sb_no_bypass", bus.hazard, 1);
      step();
      bus.lsu_valid = 1'b0;
      #1;
      chk("sb_cleared", bus.hazard, 0);
      chk("sb_lsu_writereg", bus.WriteReg, 8);
      // Same-cycle grant of rd=8 and new issue of rd=8.
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h99;
      #1;
      chk("sb_same_alu_ready", bus.alu_ready, 1);
      step();
      bus.issue_valid = 1'b0; bus.alu_valid = 1'b0; bus.issue_rs1 = 5'd8;
      #1;
      chk("sb_set_wins", bus.hazard, 1);
      chk("sb_same_wdata", bus.WData, 32'h99);
      step();
      chk("sb_set_persists", bus.hazard, 1);

      // 6. Reset the cycle after a grant, with x9 and x8 busy.
      bus.issue_rs1 = 5'd0;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      step();
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd9;
      #1;
      chk("rst6_busy9", bus.hazard, 1);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
      #1;
      chk("rst6_lsu_ready", bus.lsu_ready, 1);
      step();
      bus.lsu_valid = 1'b0; rst = 1'b1; bus.alu_valid = 1'b1; bus.alu_rd = 5'd4;
      #1;
      chk("rst6_pending_wren", bus.wren, 1);
      chk("rst6_pending_writereg", bus.WriteReg, 3);
      chk("rst6_alu_ready_in_rst", bus.alu_ready, 0);
      step();
      chk("rst6_wren_dropped", bus.wren, 0);
      chk("rst6_busy9_clear", bus.hazard, 0);
      bus.issue_rs1 = 5'd8;
      #1;
      chk("rst6_busy8_clear", bus.hazard, 0);
      // Pointer favoured LSU before reset; reset returns priority to ALU.
      rst = 1'b0; bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7;
      #1;
      chk("rst6_ptr_alu", {bus.alu_ready, bus.lsu_ready}, 2'b10);
      step();
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      chk("rst6_post_writereg", bus.WriteReg, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
